// File: rtl/q_update_engine.sv
// Q-learning update engine: owns the Q-table and applies one Bellman update per accepted transition.
// Optional macro Q_SATURATE_EN makes the adds and shifted products saturate instead of wrapping.
module q_update_engine #(
  parameter int N_STATES  = 36,
  parameter int N_ACTIONS = 4,
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 16,
  parameter logic [DATA_W-1:0] ALPHA = 32'h0000_3333,
  parameter logic [DATA_W-1:0] GAMMA = 32'h0000_E666,
  localparam int SW = $clog2(N_STATES),
  localparam int AW = $clog2(N_ACTIONS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [SW-1:0]                 req_state,
  input  logic [AW-1:0]                 req_action,
  input  logic [SW-1:0]                 req_next_state,
  input  logic [DATA_W-1:0]             req_reward,
  input  logic                          req_terminal,
  output logic                          upd_done,
  output logic                          upd_err,
  output logic [DATA_W-1:0]             upd_q,
  input  logic [SW-1:0]                 rd_state,
  output logic [N_ACTIONS*DATA_W-1:0]   rd_q,
  output logic [2:0]                    dbg_state
);
  localparam int N_ENT = N_STATES * N_ACTIONS;
  localparam int IW    = $clog2(N_ENT);
  localparam int PW    = 2 * DATA_W;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and every req_* field is captured on that edge.
  typedef enum logic [2:0] {INIT, IDLE, RD_OLD, MAX, MUL, UPD, WR} state_t;
  typedef logic signed [DATA_W-1:0] q_t;
  typedef logic signed [PW-1:0]     p_t;

`ifdef Q_SATURATE_EN
  localparam p_t Q_MAX_X = (p_t'(1) <<< (DATA_W - 1)) - p_t'(1);
  localparam p_t Q_MIN_X = -(p_t'(1) <<< (DATA_W - 1));
`endif

  function automatic q_t fit(input p_t x);
`ifdef Q_SATURATE_EN
    if (x > Q_MAX_X)      fit = q_t'(Q_MAX_X);
    else if (x < Q_MIN_X) fit = q_t'(Q_MIN_X);
    else                  fit = q_t'(x);
`else
    fit = q_t'(x);
`endif
  endfunction

  function automatic p_t ext(input q_t v);
    ext = p_t'(v);
  endfunction

  // Full-width signed product, arithmetic shift rounds toward minus infinity.
  function automatic p_t mul_shift(input q_t a, input q_t b);
    mul_shift = (ext(a) * ext(b)) >>> FRAC_W;
  endfunction

  function automatic logic [IW-1:0] ent(input int s, input int a);
    ent = IW'(s * N_ACTIONS + a);
  endfunction

  q_t mem [N_ENT];

  state_t                state_q, state_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         s_q, s_d, sp_q, sp_d;
  logic [AW-1:0]         a_q, a_d;
  q_t                    r_q, r_d, old_q, old_d, max_q, max_d, tgt_q, tgt_d, upd_q_q, upd_q_d;
  logic                  term_q, term_d, err_q, err_d;
  logic [N_ACTIONS*DATA_W-1:0] rd_q_q, rd_q_d;

  logic                  we;
  logic [IW-1:0]         waddr;
  q_t                    wdata;
  logic                  s_ok, sp_ok, a_ok;
  logic [IW-1:0]         old_idx, scan_idx;
  q_t                    scan_val, delta, new_val;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    a_d      = a_q;
    sp_d     = sp_q;
    r_d      = r_q;
    term_d   = term_q;
    err_d    = err_q;
    old_d    = old_q;
    max_d    = max_q;
    tgt_d    = tgt_q;
    upd_q_d  = upd_q_q;
    we       = 1'b0;
    waddr    = ent(int'(s_q), int'(a_q));
    wdata    = upd_q_q;
    s_ok     = int'(s_q) < N_STATES;
    sp_ok    = int'(sp_q) < N_STATES;
    a_ok     = int'(a_q) < N_ACTIONS;
    old_idx  = (s_ok && a_ok) ? ent(int'(s_q), int'(a_q)) : '0;
    scan_idx = err_q ? '0 : ent(int'(sp_q), int'(cnt_q));
    scan_val = err_q ? '0 : mem[scan_idx];
    delta    = fit(ext(tgt_q) - ext(old_q));
    new_val  = fit(ext(old_q) + ext(fit(mul_shift(q_t'(ALPHA), delta))));
    case (state_q)
      INIT: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        if (cnt_q == IW'(N_ENT - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (req_valid) begin
          s_d     = req_state;
          a_d     = req_action;
          sp_d    = req_next_state;
          r_d     = q_t'(req_reward);
          term_d  = req_terminal;
          state_d = RD_OLD;
        end
      end
      RD_OLD: begin
        err_d   = !(s_ok && sp_ok && a_ok);
        old_d   = (s_ok && a_ok) ? mem[old_idx] : '0;
        cnt_d   = '0;
        state_d = MAX;
      end
      MAX: begin
        // Strict greater-than keeps the lowest index on ties.
        if (cnt_q == '0 || scan_val > max_q) max_d = scan_val;
        if (cnt_q == IW'(N_ACTIONS - 1)) begin
          cnt_d   = '0;
          state_d = MUL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MUL: begin
        tgt_d   = fit(ext(r_q) + ext(fit(mul_shift(q_t'(GAMMA), term_q ? q_t'(0) : max_q))));
        state_d = UPD;
      end
      UPD: begin
        upd_q_d = err_q ? old_q : new_val;
        state_d = WR;
      end
      WR: begin
        we      = !err_q;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    rd_q_d = '0;
    for (int k = 0; k < N_ACTIONS; k++) begin
      if (int'(rd_state) < N_STATES)
        rd_q_d[k*DATA_W +: DATA_W] = mem[ent(int'(rd_state), k)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      s_q     <= '0;
      a_q     <= '0;
      sp_q    <= '0;
      r_q     <= '0;
      term_q  <= 1'b0;
      err_q   <= 1'b0;
      old_q   <= '0;
      max_q   <= '0;
      tgt_q   <= '0;
      upd_q_q <= '0;
      rd_q_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      a_q     <= a_d;
      sp_q    <= sp_d;
      r_q     <= r_d;
      term_q  <= term_d;
      err_q   <= err_d;
      old_q   <= old_d;
      max_q   <= max_d;
      tgt_q   <= tgt_d;
      upd_q_q <= upd_q_d;
      rd_q_q  <= rd_q_d;
    end
  end

  // Table storage has no reset of its own; INIT clears it entry by entry.
  always_ff @(posedge clk) begin
    if (!rst && we) mem[waddr] <= wdata;
  end

  assign req_ready = (state_q == IDLE);
  assign upd_done  = (state_q == WR);
  assign upd_err   = (state_q == WR) && err_q;
  assign upd_q     = upd_q_q;
  assign rd_q      = rd_q_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_q_update_engine.sv
// Bench for q_update_engine: directed vector table, reset/abort sequences and random
// transitions scored against an arithmetic model of the Q-update rule.
module tb_q_update_engine;
  localparam int NS = 36;
  localparam int NA = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [5:0]   req_state = '0;
  logic [1:0]   req_action = '0;
  logic [5:0]   req_next_state = '0;
  logic [31:0]  req_reward = '0;
  logic         req_terminal = 1'b0;
  logic         upd_done;
  logic         upd_err;
  logic [31:0]  upd_q;
  logic [5:0]   rd_state = '0;
  logic [127:0] rd_q;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  longint mq [NS*NA];

  q_update_engine dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .req_action(req_action), .req_next_state(req_next_state),
    .req_reward(req_reward), .req_terminal(req_terminal), .upd_done(upd_done),
    .upd_err(upd_err), .upd_q(upd_q), .rd_state(rd_state), .rd_q(rd_q),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint fitv(input longint x);
`ifdef Q_SATURATE_EN
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
`else
    logic [31:0] t;
    t = x[31:0];
    return longint'($signed(t));
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS*NA; i++) mq[i] = 0;
  endtask

  task automatic model_update(input int s, input int a, input int sp, input logic [31:0] r,
                              input logic t, output logic [31:0] nq, output logic ne);
    longint old, mx, tgt, dl, nw, rv;
    ne  = (s >= NS) || (sp >= NS) || (a >= NA);
    old = (s < NS && a < NA) ? mq[s*NA+a] : 0;
    if (ne) begin
      nq = old[31:0];
      return;
    end
    mx = mq[sp*NA];
    for (int k = 1; k < NA; k++) if (mq[sp*NA+k] > mx) mx = mq[sp*NA+k];
    if (t) mx = 0;
    rv  = longint'($signed(r));
    tgt = fitv(rv + fitv((64'sh0000_E666 * mx) >>> 16));
    dl  = fitv(tgt - old);
    nw  = fitv(old + fitv((64'sh0000_3333 * dl) >>> 16));
    mq[s*NA+a] = nw;
    nq = nw[31:0];
  endtask

  function automatic logic [127:0] model_row(input int st);
    logic [127:0] row;
    longint v;
    row = '0;
    for (int k = 0; k < NA; k++) begin
      v = mq[st*NA+k];
      row[k*32 +: 32] = v[31:0];
    end
    return row;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reset_and_init(input string tag);
    bit saw_done;
    saw_done = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_rst_ready"}, req_ready, 1'b0);
    chk({tag, "_rst_updq"}, upd_q, 32'h0);
    chk({tag, "_rst_rdq"}, rd_q, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= NS*NA; i++) begin
      @(posedge clk);
      #1;
      if (upd_done) saw_done = 1;
      if (i == NS*NA - 1) chk({tag, "_ready_early"}, req_ready, 1'b0);
    end
    chk({tag, "_ready_rise"}, req_ready, 1'b1);
    chk({tag, "_no_done"}, saw_done, 1'b0);
    model_clear();
  endtask

  task automatic check_rows(input string tag, input int lo, input int hi);
    for (int st = lo; st <= hi; st++) begin
      @(negedge clk);
      rd_state = 6'(st);
      @(posedge clk);
      #1;
      chk($sformatf("%s_row%0d", tag, st), rd_q, model_row(st));
    end
  endtask

  task automatic send_req(input logic [5:0] s, input logic [1:0] a, input logic [5:0] sp,
                          input logic [31:0] r, input logic t, input logic [31:0] eq,
                          input logic ee, input string tag);
    int waited;
    int lat;
    waited = 0;
    lat = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready"}, req_ready, 1'b1);
    if (!req_ready) return;
    req_valid = 1'b1;
    req_state = s;
    req_action = a;
    req_next_state = sp;
    req_reward = r;
    req_terminal = t;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_state = 6'($urandom);
    req_action = 2'($urandom);
    req_next_state = 6'($urandom);
    req_reward = $urandom;
    req_terminal = 1'($urandom);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (upd_done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 7);
    chk({tag, "_updq"}, upd_q, eq);
    chk({tag, "_upderr"}, upd_err, ee);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, upd_done, 1'b0);
    chk({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  typedef struct {
    logic [5:0]  s;
    logic [1:0]  a;
    logic [5:0]  sp;
    logic [31:0] r;
    logic        t;
    logic [31:0] eq;
    logic        ee;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [31:0] nq;
    logic        ne;
    logic [5:0]  s, sp;
    logic [1:0]  a;
    logic [31:0] r;
    logic        t;

    vt[0] = '{6'd5,  2'd2, 6'd6,  32'h000A_0000, 1'b0, 32'h0001_FFFE, 1'b0};
    vt[1] = '{6'd4,  2'd1, 6'd5,  32'h0000_0000, 1'b0, 32'h0000_5C28, 1'b0};
    vt[2] = '{6'd7,  2'd0, 6'd5,  32'hFFFF_0000, 1'b1, 32'hFFFF_CCCD, 1'b0};
    vt[3] = '{6'd40, 2'd0, 6'd1,  32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1};
    vt[4] = '{6'd5,  2'd2, 6'd5,  32'h0000_0000, 1'b0, 32'h0001_F5C0, 1'b0};
    vt[5] = '{6'd6,  2'd3, 6'd7,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vt[6] = '{6'd4,  2'd1, 6'd50, 32'h0001_0000, 1'b0, 32'h0000_5C28, 1'b1};

    reset_and_init("r0");
    check_rows("init", 0, NS-1);

    for (int i = 0; i < 7; i++) begin
      model_update(int'(vt[i].s), int'(vt[i].a), int'(vt[i].sp), vt[i].r, vt[i].t, nq, ne);
      send_req(vt[i].s, vt[i].a, vt[i].sp, vt[i].r, vt[i].t, vt[i].eq, vt[i].ee,
               $sformatf("vec%0d", i));
    end
    check_rows("after_vec", 0, 9);

    // Reset in the middle of the max scan: no completion, table wiped, INIT again.
    @(negedge clk);
    req_valid = 1'b1;
    req_state = 6'd5;
    req_action = 2'd2;
    req_next_state = 6'd5;
    req_reward = 32'h0004_0000;
    req_terminal = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_in_max", dbg_state, 3'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_done", upd_done, 1'b0);
    chk("abort_not_ready", req_ready, 1'b0);
    reset_and_init("r1");
    check_rows("abort", 0, 9);

    // Read of the row being written shows the old value, new value one cycle later.
    @(negedge clk);
    rd_state = 6'd3;
    model_update(3, 0, 9, 32'h0001_0000, 1'b0, nq, ne);
    send_req(6'd3, 2'd0, 6'd9, 32'h0001_0000, 1'b0, 32'h0000_3333, 1'b0, "rdw");
    chk("rdw_prewrite", rd_q[31:0], 32'h0);
    @(posedge clk);
    #1;
    chk("rdw_postwrite", rd_q[31:0], 32'h0000_3333);

    for (int i = 0; i < 40; i++) begin
      s  = 6'($urandom_range(0, 9));
      sp = 6'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) s  = 6'(36 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) sp = 6'(36 + $urandom_range(0, 20));
      a  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) r = $urandom;
      else r = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      t  = ($urandom_range(0, 4) == 0);
      model_update(int'(s), int'(a), int'(sp), r, t, nq, ne);
      send_req(s, a, sp, r, t, nq, ne, $sformatf("rnd%0d", i));
    end
    check_rows("final", 0, NS-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
